// File: rtl/potential_adder_array.sv
// potential_adder_array
// Time-multiplexed FP32 leaky integrate-and-fire membrane update engine.
// During a timestep, weighted-spike contributions arrive over a valid/ready
// handshake. Each one is added into a per-neuron accumulator in the cycle it
// is accepted. A ts_end pulse starts a sequential sweep that evaluates one
// neuron per clock: decay, add, threshold, reset and refractory. The sweep
// ends by publishing the spike vector together with a one-cycle done pulse.
//
// Ports:
//   CLK                 clock
//   clear               synchronous active-high reset
//   cfg_set             load threshold/decay/model (only while idle)
//   cfg_v_threshold     FP32 firing threshold
//   cfg_decay           FP32 decay multiplier
//   cfg_model           00/1x subtract-threshold, 01 reset-to-zero
//   in_valid/in_ready   contribution handshake
//   in_idx, in_weight   target neuron and FP32 weight
//   ts_end              timestep-end pulse
//   busy                evaluation sweep in progress
//   spike_vec           spikes of the last completed timestep
//   done                one-cycle pulse when spike_vec/potentials are final
//   err                 sticky FP exception / out-of-range index flag
//   rd_idx/rd_potential combinational debug read of a committed potential
module potential_adder_array #(
  parameter int NUM_NEURONS = 30,
  parameter int IDX_W       = 5,
  parameter int REFRACT_TS  = 0,
  parameter int REFRACT_W   = 4
) (
  input  logic                   CLK,
  input  logic                   clear,
  input  logic                   cfg_set,
  input  logic [31:0]            cfg_v_threshold,
  input  logic [31:0]            cfg_decay,
  input  logic [1:0]             cfg_model,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IDX_W-1:0]       in_idx,
  input  logic [31:0]            in_weight,
  input  logic                   ts_end,
  output logic                   busy,
  output logic [NUM_NEURONS-1:0] spike_vec,
  output logic                   done,
  output logic                   err,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [31:0]            rd_potential
);

  localparam logic [31:0] THR_RST   = 32'h42200000;  // 40.0
  localparam logic [31:0] DECAY_RST = 32'h3F800000;  // 1.0

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;
  typedef struct packed {
    logic [31:0] val;
    logic        exc;
  } fp_res_t;

  // Rounds a 27-bit mantissa (bit 26 = hidden one, bits 2..0 = guard, round,
  // sticky) to nearest-even and packs it. Denormal results flush to zero.
  function automatic fp_res_t fp_round_pack(input logic sign, input int exp_in,
                                            input logic [26:0] m);
    fp_res_t    res;
    logic [24:0] mr;
    logic        rnd;
    int          e;
    e   = exp_in;
    rnd = m[2] & (m[1] | m[0] | m[3]);
    mr  = {1'b0, m[26:3]} + {24'd0, rnd};
    if (mr[24]) begin
      e  = e + 1;
      mr = mr >> 1;
    end
    res.exc = 1'b0;
    if (e >= 255) begin
      res.val = {sign, 8'hFF, 23'd0};
      res.exc = 1'b1;
    end else if (e <= 0) begin
      res.val = {sign, 31'd0};
      res.exc = 1'b1;
    end else begin
      res.val = {sign, e[7:0], mr[22:0]};
    end
    return res;
  endfunction

  // FP32 add. Inf/NaN operands raise the exception flag; denormals read as 0.
  function automatic fp_res_t fp_add(input logic [31:0] a, input logic [31:0] b);
    fp_res_t     res;
    logic [31:0] big, sml;
    logic [26:0] mb, ms, lost;
    logic [27:0] sum;
    logic [7:0]  diff;
    logic        found;
    int          lz;
    res.val = 32'd0;
    res.exc = 1'b0;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      res.val = 32'h7FC00000;
      res.exc = 1'b1;
    end else if (a[30:23] == 8'd0 && b[30:23] == 8'd0) begin
      res.val = {a[31] & b[31], 31'd0};
    end else if (a[30:23] == 8'd0) begin
      res.val = b;
    end else if (b[30:23] == 8'd0) begin
      res.val = a;
    end else begin
      if (a[30:0] >= b[30:0]) begin
        big = a;
        sml = b;
      end else begin
        big = b;
        sml = a;
      end
      diff = big[30:23] - sml[30:23];
      mb   = {1'b1, big[22:0], 3'b000};
      ms   = {1'b1, sml[22:0], 3'b000};
      if (diff > 8'd26) begin
        ms = 27'd1;
      end else begin
        lost = ms << (8'd27 - diff);
        ms   = (ms >> diff) | {26'd0, |lost};
      end
      if (big[31] == sml[31]) begin
        sum = {1'b0, mb} + {1'b0, ms};
        if (sum[27])
          res = fp_round_pack(big[31], int'(big[30:23]) + 1, {sum[27:2], sum[1] | sum[0]});
        else
          res = fp_round_pack(big[31], int'(big[30:23]), sum[26:0]);
      end else begin
        // |big| >= |sml|, so the difference never goes negative.
        sum = {1'b0, mb} - {1'b0, ms};
        if (sum == 28'd0) begin
          res.val = 32'd0;
        end else begin
          lz    = 0;
          found = 1'b0;
          for (int i = 26; i >= 0; i--) begin
            if (!found && sum[i]) begin
              lz    = 26 - i;
              found = 1'b1;
            end
          end
          sum = sum << lz;
          res = fp_round_pack(big[31], int'(big[30:23]) - lz, sum[26:0]);
        end
      end
    end
    return res;
  endfunction

  // FP32 multiply with the same operand handling as fp_add.
  function automatic fp_res_t fp_mul(input logic [31:0] a, input logic [31:0] b);
    fp_res_t     res;
    logic [47:0] p;
    logic        sign;
    sign    = a[31] ^ b[31];
    res.val = {sign, 31'd0};
    res.exc = 1'b0;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      res.val = 32'h7FC00000;
      res.exc = 1'b1;
    end else if (a[30:23] != 8'd0 && b[30:23] != 8'd0) begin
      p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      if (p[47])
        res = fp_round_pack(sign, int'(a[30:23]) + int'(b[30:23]) - 126, {p[47:22], |p[21:0]});
      else
        res = fp_round_pack(sign, int'(a[30:23]) + int'(b[30:23]) - 127, {p[46:21], |p[20:0]});
    end
    return res;
  endfunction

  // Strict a > b. Returns {exception, greater}. +0 and -0 compare equal.
  function automatic logic [1:0] fp_gt(input logic [31:0] a, input logic [31:0] b);
    logic [1:0] r;
    r = 2'b00;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
      r = 2'b10;
    else if (a[30:0] == 31'd0 && b[30:0] == 31'd0)
      r = 2'b00;
    else if (a[31] != b[31])
      r = {1'b0, ~a[31]};
    else if (!a[31])
      r = {1'b0, a[30:0] > b[30:0]};
    else
      r = {1'b0, a[30:0] < b[30:0]};
    return r;
  endfunction

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       ptr_reg;
  logic [31:0]            thr_reg, decay_reg;
  logic [1:0]             model_reg;
  logic [NUM_NEURONS-1:0] spike_vec_reg, spike_acc_reg, spike_merge;
  logic                   err_reg;

  logic [31:0]            pot_all [NUM_NEURONS];
  logic [31:0]            acc_all [NUM_NEURONS];
  logic [REFRACT_W-1:0]   ref_all [NUM_NEURONS];

  logic                   in_range, handshake, acc_hit, eval_en, last_neuron;
  logic [31:0]            acc_sel, pot_cur, acc_cur, eval_pot;
  logic [REFRACT_W-1:0]   ref_sel, ref_cur, eval_ref;
  fp_res_t                acc_res, prod_res, v_res, sub_res;
  logic [1:0]             cmp_res;
  logic                   refractory, eval_spike, eval_exc, set_err;

  assign in_ready    = (state_reg == S_IDLE);
  assign busy        = (state_reg == S_EVAL);
  assign done        = (state_reg == S_DONE);
  assign err         = err_reg;
  assign spike_vec   = spike_vec_reg;
  assign eval_en     = (state_reg == S_EVAL);
  assign last_neuron = (ptr_reg == IDX_W'(NUM_NEURONS - 1));
  assign in_range    = (32'(in_idx) < NUM_NEURONS);
  assign handshake   = in_valid & in_ready;
  assign rd_potential = (32'(rd_idx) < NUM_NEURONS) ? pot_all[rd_idx] : 32'd0;

  // Contribution path: the accumulator is read and rewritten in one cycle,
  // so back-to-back hits to one neuron always see the previous sum.
  always_comb begin
    acc_sel = 32'd0;
    ref_sel = '0;
    if (in_range) begin
      acc_sel = acc_all[in_idx];
      ref_sel = ref_all[in_idx];
    end
    acc_hit = handshake && in_range && (ref_sel == '0);
    acc_res = fp_add(acc_sel, in_weight);
  end

  // Evaluation path for neuron ptr_reg.
  always_comb begin
    pot_cur    = pot_all[ptr_reg];
    acc_cur    = acc_all[ptr_reg];
    ref_cur    = ref_all[ptr_reg];
    prod_res   = fp_mul(decay_reg, pot_cur);
    v_res      = fp_add(prod_res.val, acc_cur);
    cmp_res    = fp_gt(v_res.val, thr_reg);
    sub_res    = fp_add(v_res.val, thr_reg ^ 32'h80000000);
    refractory = (ref_cur != '0);
    eval_spike = !refractory && cmp_res[0];
    eval_pot   = v_res.val;
    eval_ref   = '0;
    if (refractory) begin
      eval_pot = 32'd0;
      eval_ref = ref_cur - 1'b1;
    end else if (cmp_res[0]) begin
      eval_pot = (model_reg == 2'b01) ? 32'd0 : sub_res.val;
      eval_ref = REFRACT_W'(REFRACT_TS);
    end
    eval_exc = eval_en && !refractory &&
               (prod_res.exc || v_res.exc || cmp_res[1] ||
                (cmp_res[0] && model_reg != 2'b01 && sub_res.exc));
    set_err  = eval_exc || (handshake && !in_range) || (acc_hit && acc_res.exc);
    spike_merge          = spike_acc_reg;
    spike_merge[ptr_reg] = eval_spike;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (ts_end) state_next = S_EVAL;
      S_EVAL:  if (last_neuron) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (clear) begin
      state_reg     <= S_IDLE;
      ptr_reg       <= '0;
      thr_reg       <= THR_RST;
      decay_reg     <= DECAY_RST;
      model_reg     <= 2'b00;
      spike_vec_reg <= '0;
      spike_acc_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && cfg_set) begin
        thr_reg   <= cfg_v_threshold;
        decay_reg <= cfg_decay;
        model_reg <= cfg_model;
      end
      if (state_reg == S_IDLE)
        ptr_reg <= '0;
      else if (eval_en)
        ptr_reg <= ptr_reg + 1'b1;
      // Spikes collect in a shadow so spike_vec only changes when the sweep
      // completes, in the same edge that enters DONE.
      if (eval_en) begin
        spike_acc_reg <= spike_merge;
        if (last_neuron)
          spike_vec_reg <= spike_merge;
      end
      if (set_err)
        err_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_neuron
    logic [31:0]          pot_reg, acc_reg;
    logic [REFRACT_W-1:0] ref_reg;
    logic                 eval_sel, acc_sel_hit;

    assign eval_sel    = eval_en && (ptr_reg == IDX_W'(gi));
    assign acc_sel_hit = acc_hit && (in_idx == IDX_W'(gi));

    always_ff @(posedge CLK) begin
      if (clear) begin
        pot_reg <= 32'd0;
        acc_reg <= 32'd0;
        ref_reg <= '0;
      end else if (eval_sel) begin
        pot_reg <= eval_pot;
        acc_reg <= 32'd0;
        ref_reg <= eval_ref;
      end else if (acc_sel_hit) begin
        acc_reg <= acc_res.val;
      end
    end

    assign pot_all[gi] = pot_reg;
    assign acc_all[gi] = acc_reg;
    assign ref_all[gi] = ref_reg;
  end

endmodule

// File: tb/tb_potential_adder_array.sv
// Directed bench for potential_adder_array. Two instances share all inputs:
// dut uses no refractory period, dut_r uses REFRACT_TS=2.
module tb_potential_adder_array;

  localparam int N = 30;

  localparam logic [31:0] F_0_5  = 32'h3F000000;
  localparam logic [31:0] F_1    = 32'h3F800000;
  localparam logic [31:0] F_10   = 32'h41200000;
  localparam logic [31:0] F_12_5 = 32'h41480000;
  localparam logic [31:0] F_20   = 32'h41A00000;
  localparam logic [31:0] F_25   = 32'h41C80000;
  localparam logic [31:0] F_30   = 32'h41F00000;
  localparam logic [31:0] F_40   = 32'h42200000;
  localparam logic [31:0] F_50   = 32'h42480000;
  localparam logic [31:0] F_60   = 32'h42700000;
  localparam logic [31:0] F_100  = 32'h42C80000;
  localparam logic [31:0] F_120  = 32'h42F00000;
  localparam logic [31:0] F_1000 = 32'h447A0000;

  logic          CLK = 1'b0;
  logic          clear, cfg_set, in_valid, ts_end;
  logic [31:0]   cfg_v_threshold, cfg_decay, in_weight;
  logic [1:0]    cfg_model;
  logic [4:0]    in_idx, rd_idx;

  logic          in_ready, busy, done, err;
  logic [N-1:0]  spike_vec;
  logic [31:0]   rd_potential;
  logic          in_ready_r, busy_r, done_r, err_r;
  logic [N-1:0]  spike_vec_r;
  logic [31:0]   rd_potential_r;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  potential_adder_array #(.NUM_NEURONS(N), .IDX_W(5), .REFRACT_TS(0), .REFRACT_W(4)) dut (
    .CLK(CLK), .clear(clear), .cfg_set(cfg_set), .cfg_v_threshold(cfg_v_threshold),
    .cfg_decay(cfg_decay), .cfg_model(cfg_model), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .in_weight(in_weight), .ts_end(ts_end), .busy(busy),
    .spike_vec(spike_vec), .done(done), .err(err), .rd_idx(rd_idx), .rd_potential(rd_potential)
  );

  potential_adder_array #(.NUM_NEURONS(N), .IDX_W(5), .REFRACT_TS(2), .REFRACT_W(4)) dut_r (
    .CLK(CLK), .clear(clear), .cfg_set(cfg_set), .cfg_v_threshold(cfg_v_threshold),
    .cfg_decay(cfg_decay), .cfg_model(cfg_model), .in_valid(in_valid), .in_ready(in_ready_r),
    .in_idx(in_idx), .in_weight(in_weight), .ts_end(ts_end), .busy(busy_r),
    .spike_vec(spike_vec_r), .done(done_r), .err(err_r), .rd_idx(rd_idx), .rd_potential(rd_potential_r)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic cfg(input logic [31:0] thr, input logic [31:0] dec, input logic [1:0] model);
    cfg_set = 1'b1;
    cfg_v_threshold = thr;
    cfg_decay = dec;
    cfg_model = model;
    step();
    cfg_set = 1'b0;
  endtask

  task automatic send(input logic [4:0] idx, input logic [31:0] w);
    in_valid = 1'b1;
    in_idx = idx;
    in_weight = w;
    step();
    in_valid = 1'b0;
    $display("send idx=%0d w=%h err=%b", idx, w, err);
  endtask

  // Pulses ts_end (any contribution already on the inputs rides along) and
  // waits, with a bounded budget, for done; returns the latency in cycles.
  task automatic run_ts(output int lat);
    ts_end = 1'b1;
    step();
    ts_end = 1'b0;
    in_valid = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      step();
      lat++;
    end
    if (lat < 100) step();
    $display("timestep lat=%0d spike_vec=%h spike_vec_r=%h", lat, spike_vec, spike_vec_r);
  endtask

  task automatic read_pot(input logic [4:0] idx, output logic [31:0] v, output logic [31:0] vr);
    rd_idx = idx;
    #1;
    v = rd_potential;
    vr = rd_potential_r;
  endtask

  initial begin
    int lat;
    int dones;
    logic [31:0] p, pr;

    clear = 1'b1; cfg_set = 1'b0; in_valid = 1'b0; ts_end = 1'b0;
    cfg_v_threshold = 32'd0; cfg_decay = 32'd0; cfg_model = 2'b00;
    in_idx = 5'd0; in_weight = 32'd0; rd_idx = 5'd0;
    repeat (3) step();
    clear = 1'b0;

    // Reset state
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_err", {31'd0, err}, 32'd0);
    check_val("rst_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_spike", {2'd0, spike_vec}, 32'd0);
    read_pot(5'd0, p, pr);
    check_val("rst_pot0", p, 32'd0);

    // 1: 25+25 at idx 3 -> 50 > 40, potential 10
    send(5'd3, F_25);
    send(5'd3, F_25);
    run_ts(lat);
    check_val("t1_lat", lat, 31);
    check_val("t1_spike", {2'd0, spike_vec}, 32'h8);
    for (int i = 0; i < N; i++) begin
      read_pot(5'(i), p, pr);
      check_val($sformatf("t1_pot%0d", i), p, (i == 3) ? F_10 : 32'd0);
    end

    // 2: reset-to-zero mode, then exactly-threshold does not fire
    cfg(F_40, F_1, 2'b01);
    send(5'd3, F_25);
    send(5'd3, F_25);
    run_ts(lat);
    check_val("t2_lat", lat, 31);
    check_val("t2_spike", {2'd0, spike_vec}, 32'h8);
    read_pot(5'd3, p, pr);
    check_val("t2_pot3_zero", p, 32'd0);
    send(5'd3, F_20);
    send(5'd3, F_20);
    run_ts(lat);
    check_val("t2_eq_spike", {2'd0, spike_vec}, 32'd0);
    read_pot(5'd3, p, pr);
    check_val("t2_eq_pot3", p, F_40);

    // 3: decay 0.5 on potential 30 plus 10 -> 25
    do_reset();
    send(5'd5, F_30);
    run_ts(lat);
    read_pot(5'd5, p, pr);
    check_val("t3_pot5_30", p, F_30);
    cfg(F_40, F_0_5, 2'b00);
    send(5'd5, F_10);
    run_ts(lat);
    check_val("t3_spike", {2'd0, spike_vec}, 32'd0);
    read_pot(5'd5, p, pr);
    check_val("t3_pot5_25", p, F_25);

    // 5: out-of-range index drops and flags; contribution with ts_end counts
    check_val("t5_err0", {31'd0, err}, 32'd0);
    send(5'd31, F_50);
    check_val("t5_err1", {31'd0, err}, 32'd1);
    in_valid = 1'b1; in_idx = 5'd7; in_weight = F_10;
    run_ts(lat);
    check_val("t5_lat", lat, 31);
    check_val("t5_spike", {2'd0, spike_vec}, 32'd0);
    read_pot(5'd7, p, pr);
    check_val("t5_pot7", p, F_10);
    read_pot(5'd5, p, pr);
    check_val("t5_pot5", p, F_12_5);
    check_val("t5_err_sticky", {31'd0, err}, 32'd1);

    // 4: refractory period of two timesteps on dut_r
    do_reset();
    send(5'd0, F_100);
    run_ts(lat);
    check_val("t4_r_spike1", {2'd0, spike_vec_r}, 32'd1);
    read_pot(5'd0, p, pr);
    check_val("t4_r_pot1", pr, F_60);
    for (int t = 0; t < 2; t++) begin
      send(5'd0, F_100);
      run_ts(lat);
      check_val($sformatf("t4_r_spike_ref%0d", t), {2'd0, spike_vec_r}, 32'd0);
      read_pot(5'd0, p, pr);
      check_val($sformatf("t4_r_pot_ref%0d", t), pr, 32'd0);
      if (t == 0) begin
        check_val("t4_nr_spike", {2'd0, spike_vec}, 32'd1);
        check_val("t4_nr_pot", p, F_120);
      end
    end
    send(5'd0, F_100);
    run_ts(lat);
    check_val("t4_r_spike3", {2'd0, spike_vec_r}, 32'd1);
    read_pot(5'd0, p, pr);
    check_val("t4_r_pot3", pr, F_60);

    // 6a: ts_end and cfg_set during EVAL are ignored
    do_reset();
    send(5'd2, F_30);
    run_ts(lat);
    send(5'd2, F_30);
    ts_end = 1'b1;
    step();
    ts_end = 1'b0;
    lat = 1;
    repeat (4) begin step(); lat++; end
    ts_end = 1'b1; cfg_set = 1'b1; cfg_v_threshold = F_1000; cfg_decay = F_0_5; cfg_model = 2'b01;
    step();
    lat++;
    ts_end = 1'b0; cfg_set = 1'b0;
    check_val("t6_busy", {31'd0, busy}, 32'd1);
    check_val("t6_ready", {31'd0, in_ready}, 32'd0);
    while (!done && lat < 100) begin step(); lat++; end
    check_val("t6_lat", lat, 31);
    dones = 0;
    repeat (40) begin step(); if (done) dones++; end
    check_val("t6_no_redo", dones, 0);
    check_val("t6_spike", {2'd0, spike_vec}, 32'h4);
    read_pot(5'd2, p, pr);
    check_val("t6_pot2", p, F_20);

    // 6b: clear in the middle of EVAL
    send(5'd2, F_30);
    ts_end = 1'b1;
    step();
    ts_end = 1'b0;
    repeat (9) step();
    check_val("t6_busy_mid", {31'd0, busy}, 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_val("t6_clr_busy", {31'd0, busy}, 32'd0);
    check_val("t6_clr_done", {31'd0, done}, 32'd0);
    check_val("t6_clr_spike", {2'd0, spike_vec}, 32'd0);
    check_val("t6_clr_err", {31'd0, err}, 32'd0);
    check_val("t6_clr_ready", {31'd0, in_ready}, 32'd1);
    read_pot(5'd2, p, pr);
    check_val("t6_clr_pot2", p, 32'd0);
    dones = 0;
    repeat (40) begin step(); if (done) dones++; end
    check_val("t6_clr_nodone", dones, 0);
    $display("clear mid-eval: busy=%b spike_vec=%h", busy, spike_vec);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/potential_adder_array.md
Name: potential_adder_array

Overview:
- Time-multiplexed FP32 leaky integrate-and-fire membrane update engine for NUM_NEURONS neurons.
- Replaces per-neuron combinational potential adders.
- During a timestep, accepts weighted-spike contributions through a valid/ready handshake and accumulates them per neuron.
- On timestep end, evaluates every neuron sequentially (decay, add, threshold, reset, refractory) and publishes a spike vector with a done pulse.

Parameters:
NUM_NEURONS, 30, neurons held in the array
IDX_W, 5, neuron index width; must satisfy 2^IDX_W >= NUM_NEURONS
REFRACT_TS, 0, timesteps a neuron stays refractory after spiking (0 = none)
REFRACT_W, 4, refractory counter width

Ports:
CLK  in  1  clock; single clock domain
clear  in  1  synchronous active-high reset
cfg_set  in  1  load configuration (honoured only in IDLE)
cfg_v_threshold  in  32  FP32 threshold
cfg_decay  in  32  FP32 decay multiplier
cfg_model  in  2  reset mode: 00 subtract-threshold, 01 reset-to-zero, 1x treated as 00
in_valid  in  1  contribution valid
in_ready  out  1  block can accept a contribution
in_idx  in  IDX_W  target neuron
in_weight  in  32  FP32 weight
ts_end  in  1  timestep-end request (single-cycle pulse)
busy  out  1  evaluation in progress
spike_vec  out  NUM_NEURONS  spikes of the last evaluated timestep
done  out  1  one-cycle pulse; spike_vec and potentials updated
err  out  1  sticky: FP exception or out-of-range in_idx
rd_idx  in  IDX_W  debug potential read address
rd_potential  out  32  combinational read of potential[rd_idx]

Behaviour:
- Reset (clear=1 at CLK edge), any state, including mid-evaluation:
  - state=IDLE; all potentials, accumulators and refractory counters = 0.
  - spike_vec=0, done=0, busy=0, err=0.
  - Threshold = 32'h42200000 (40.0), decay = 32'h3F800000 (1.0), model = 00.
  - An aborted evaluation leaves no partial update.
- Arithmetic:
  - Uses the codebase Addition_Subtraction, Multiplication and comparator instances.
  - Spike condition is strictly greater-than; equality does not spike.
  - Any exception flag from these instances sets err; the result is still stored.
- States: IDLE -> EVAL -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - A handshake (in_valid & in_ready) with in_idx < NUM_NEURONS performs acc[in_idx] <= acc[in_idx] + in_weight in the same cycle. Back-to-back hits to the same index accumulate correctly with no bubbles.
  - in_idx >= NUM_NEURONS: contribution dropped, err set.
  - Contributions to a neuron with refractory count > 0 are dropped silently.
  - cfg_set loads all three config fields at the edge.
- ts_end in IDLE:
  - A handshake in the same cycle is applied first.
  - Next state EVAL, pointer n=0, busy=1, in_ready=0.
  - ts_end outside IDLE is ignored. cfg_set outside IDLE is ignored.
- EVAL, one neuron per cycle, n = 0..NUM_NEURONS-1:
  - If ref[n] > 0: ref[n] decrements, potential[n]=0, spike_vec[n]=0, acc[n]=0.
  - Else v = decay*potential[n] + acc[n].
  - If v > threshold: spike_vec[n]=1, ref[n]=REFRACT_TS, potential[n] = v - threshold (mode 00) or 0 (mode 01).
  - Otherwise spike_vec[n]=0 and potential[n]=v.
  - acc[n] is cleared after use.
  - After n = NUM_NEURONS-1, go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0; the next state is IDLE.
  - ts_end-to-done latency = NUM_NEURONS+1 cycles.
- spike_vec holds its value until the next evaluation overwrites it, or until reset.
- rd_potential reflects committed potentials only.

Test Plan:
1. Reset, then decay 1.0, threshold 40.0. Send two weights 32'h41C80000 (25.0) to idx 3, then ts_end -> done after 31 cycles, spike_vec=1<<3, rd_potential[3]=32'h41200000 (10.0), all other potentials 0.
2. Same stimulus with cfg_model=01 -> spike_vec[3]=1, potential[3]=0. Weights 20.0+20.0 (exactly 40.0) -> no spike, potential 32'h42200000.
3. Decay 32'h3F000000 (0.5), potential[5]=30.0, new weight 10.0, ts_end -> potential[5]=32'h41C80000 (25.0), no spike.
4. REFRACT_TS=2. Neuron 0 spikes. Send weight 100.0 to idx 0 in each of the next two timesteps -> no spike, potential 0 in both. The third timestep accepts the weight and spikes.
5. in_idx=31 with valid -> dropped, err=1, accumulators unchanged. in_valid together with ts_end -> that weight is counted in the ending timestep.
6. Assert clear at EVAL cycle 10 -> all outputs reset, busy=0, no done pulse. ts_end during EVAL and cfg_set during EVAL are ignored.
